lcd_msg_scheduler: RTL and testbench

Sequencer and arbiter for the shared 16×2 LCD message writer in the access-control system. Collects message requests from the keypad/user-flow, door and intruder-detection logic, picks one by fixed priority, and drives the writer's message select with a write handshake. Enforces a minimum on-screen hold time and powers the display down after inactivity or loss of presence. Sits between the system FSMs and the LCD message writer.

---
 rtl/lcd_ctrl_pkg.sv | 23 ++
 rtl/lcd_prio_enc.sv | 23 ++
 rtl/lcd_msg_scheduler.sv | 149 ++++++++++++++
 tb/tb_lcd_msg_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared LCD control definitions: message codes, scheduler state encoding, helpers.
// Used by the message scheduler and the LCD message writer.
package lcd_ctrl_pkg;

  typedef logic [1:0] msg_code_t;

  localparam msg_code_t MSG_USUARIO = 2'd0;
  localparam msg_code_t MSG_CLAVE   = 2'd1;
  localparam msg_code_t MSG_ABIERTO = 2'd2;
  localparam msg_code_t MSG_INTRUSO = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  function automatic logic [3:0] msg_onehot(input msg_code_t code);
    return 4'b0001 << code;
  endfunction

endpackage

// File: rtl/lcd_prio_enc.sv
// Fixed-priority encoder for pending LCD requests (intruso > abierto > clave > usuario).
// Purely combinational, zero latency, no backpressure.
module lcd_prio_enc
  import lcd_ctrl_pkg::*;
(
  input  logic [3:0] pend_i,
  output logic [1:0] code_o,
  output logic       any_o
);

  always_comb begin
    code_o = MSG_USUARIO;
    any_o  = |pend_i;
    if (pend_i[3]) begin
      code_o = MSG_INTRUSO;
    end else if (pend_i[2]) begin
      code_o = MSG_ABIERTO;
    end else if (pend_i[1]) begin
      code_o = MSG_CLAVE;
    end
  end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Arbitrates message requests onto the shared LCD writer with hold time and idle power-down.
// Registered outputs; grant 1 cycle after a visible flag; requests wait in pending while the writer is busy.
module lcd_msg_scheduler
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_TICKS = 150_000_000,
  parameter int unsigned IDLE_TICKS = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_usuario,
  input  logic       req_clave,
  input  logic       req_abierto,
  input  logic       req_intruso,
  input  logic       presence,
  input  logic       lcd_done,
  output logic       lcd_on,
  output logic [1:0] mns,
  output logic       msg_valid,
  output logic       busy,
  output logic [3:0] pending
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int IDLE_W = $clog2(IDLE_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TICKS);

  lcd_state_e        state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        mns_q, mns_d;
  logic              msg_valid_q, msg_valid_d;
  logic              busy_q, busy_d;
  logic              lcd_on_q, lcd_on_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  logic [3:0] req_vec;
  logic [3:0] same_vec;
  logic [3:0] enc_in;
  logic [3:0] clr_vec;
  logic [1:0] enc_code;
  logic       enc_any;
  logic       grant;
  logic [1:0] grant_code;
  logic       hold_sat;
  logic       idle_exp;

  assign req_vec  = {req_intruso, req_abierto, req_clave, req_usuario};
  assign hold_sat = (hold_q == HOLD_MAX);
  assign idle_exp = (idle_q == IDLE_MAX);

  // While holding, a request for the message already on screen is dropped without a rewrite.
  assign same_vec = (state_q == ST_HOLD) ? msg_onehot(mns_q) : 4'b0000;
  assign enc_in   = pending_q & ~same_vec;

  lcd_prio_enc u_prio_enc (
    .pend_i (enc_in),
    .code_o (enc_code),
    .any_o  (enc_any)
  );

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_code = mns_q;
    clr_vec    = same_vec;
    hold_d     = '0;
    idle_d     = '0;

    case (state_q)
      ST_OFF: begin
        if ((|pending_q) || presence) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        if (enc_any) begin
          grant      = 1'b1;
          grant_code = enc_code;
        end else if (presence) begin
          grant      = 1'b1;
          grant_code = MSG_USUARIO;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_WRITE: begin
        if (lcd_done) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        hold_d = hold_sat ? hold_q : hold_q + HOLD_W'(1);
        // Intruso on screen must never blank, so its idle count stays pinned at zero.
        if (!presence && (pending_q == 4'b0000) && (mns_q != MSG_INTRUSO)) begin
          idle_d = idle_exp ? idle_q : idle_q + IDLE_W'(1);
        end
        if (enc_in[MSG_INTRUSO]) begin
          grant      = 1'b1;
          grant_code = MSG_INTRUSO;
        end else if (enc_any && hold_sat) begin
          grant      = 1'b1;
          grant_code = enc_code;
        end else if (idle_exp) begin
          state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase

    if (grant) begin
      state_d = ST_WRITE;
      clr_vec = clr_vec | msg_onehot(grant_code);
    end

    // New requests win over a same-cycle clear.
    pending_d   = (pending_q & ~clr_vec) | req_vec;
    mns_d       = grant ? grant_code : mns_q;
    msg_valid_d = grant;
    busy_d      = (state_d == ST_WRITE);
    lcd_on_d    = (state_d != ST_OFF);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_OFF;
      pending_q   <= 4'b0000;
      mns_q       <= MSG_USUARIO;
      msg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      lcd_on_q    <= 1'b0;
      hold_q      <= '0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mns_q       <= mns_d;
      msg_valid_q <= msg_valid_d;
      busy_q      <= busy_d;
      lcd_on_q    <= lcd_on_d;
      hold_q      <= hold_d;
      idle_q      <= idle_d;
    end
  end

  assign lcd_on    = lcd_on_q;
  assign mns       = mns_q;
  assign msg_valid = msg_valid_q;
  assign busy      = busy_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Directed bench for lcd_msg_scheduler with a per-cycle reference model and literal timing pins.
module tb_lcd_msg_scheduler;

  localparam int HT = 20;
  localparam int IT = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_usuario, req_clave, req_abierto, req_intruso;
  logic       presence, lcd_done;
  logic       lcd_on, msg_valid, busy;
  logic [1:0] mns;
  logic [3:0] pending;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_msg_scheduler #(.HOLD_TICKS(HT), .IDLE_TICKS(IT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_usuario (req_usuario),
    .req_clave   (req_clave),
    .req_abierto (req_abierto),
    .req_intruso (req_intruso),
    .presence    (presence),
    .lcd_done    (lcd_done),
    .lcd_on      (lcd_on),
    .mns         (mns),
    .msg_valid   (msg_valid),
    .busy        (busy),
    .pending     (pending)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: display phase, shown code, pending set, unbounded ages.
  typedef enum {M_OFF, M_WAKE, M_WRITE, M_HOLD} mph_e;
  mph_e       ph = M_OFF;
  mph_e       nph;
  logic [3:0] pend = 4'b0000;
  logic [3:0] clr, rem;
  logic [1:0] shown = 2'd0;
  logic       mv = 1'b0;
  int         hold_age = 0;
  int         quiet_age = 0;
  int         g;
  logic       mdl_ok = 1'b0;

  function automatic int highest(input logic [3:0] v);
    int h;
    h = -1;
    for (int i = 0; i < 4; i++) if (v[i]) h = i;
    return h;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      ph = M_OFF; pend = 4'b0000; shown = 2'd0; mv = 1'b0;
      hold_age = 0; quiet_age = 0; mdl_ok = 1'b1;
    end else begin
      nph = ph; g = -1; clr = 4'b0000;
      case (ph)
        M_OFF:   if (pend != 0 || presence) nph = M_WAKE;
        M_WAKE: begin
          if (pend != 0) g = highest(pend);
          else if (presence) g = 0;
          else nph = M_OFF;
        end
        M_WRITE: if (lcd_done) begin nph = M_HOLD; hold_age = 0; quiet_age = 0; end
        M_HOLD: begin
          clr[shown] = pend[shown];
          rem = pend & ~clr;
          if (rem[3]) g = 3;
          else if (rem != 0 && hold_age >= HT) g = highest(rem);
          else if (quiet_age >= IT) nph = M_OFF;
          quiet_age = (!presence && pend == 0 && shown != 2'd3) ? quiet_age + 1 : 0;
          hold_age++;
        end
        default: nph = M_OFF;
      endcase
      mv = (g >= 0);
      if (g >= 0) begin
        nph = M_WRITE;
        shown = g[1:0];
        clr[g] = 1'b1;
      end
      pend = (pend & ~clr) | {req_intruso, req_abierto, req_clave, req_usuario};
      ph = nph;
    end
  end

  always @(negedge clk) begin
    if (mdl_ok) begin
      chk("cyc_lcd_on", lcd_on, (ph != M_OFF));
      chk("cyc_busy", busy, (ph == M_WRITE));
      chk("cyc_msg_valid", msg_valid, mv);
      chk("cyc_mns", mns, shown);
      chk("cyc_pending", pending, pend);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic d);
    {req_intruso, req_abierto, req_clave, req_usuario} = r;
    lcd_done = d;
    step();
    {req_intruso, req_abierto, req_clave, req_usuario} = 4'b0000;
    lcd_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int off_cnt;
    reset = 1'b0; presence = 1'b0; lcd_done = 1'b0;
    {req_intruso, req_abierto, req_clave, req_usuario} = 4'b0000;
    step(); step();

    // Request during reset is discarded
    drive(4'b0010, 1'b0);
    chk("rst_lcd_on", lcd_on, 0);
    chk("rst_mns", mns, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 4'b0000);
    reset = 1'b1;
    step();
    chk("post_rst_pending", pending, 4'b0000);
    chk("post_rst_lcd_on", lcd_on, 0);

    // Wake from OFF on clave
    drive(4'b0010, 1'b0);
    chk("off_flag", pending, 4'b0010);
    chk("off_still_off", lcd_on, 0);
    step();
    chk("wake_lcd_on", lcd_on, 1);
    chk("wake_no_mv", msg_valid, 0);
    step();
    chk("wake_mv", msg_valid, 1);
    chk("wake_mns", mns, 1);
    chk("wake_busy", busy, 1);
    chk("wake_flag_clr", pending, 4'b0000);
    step();
    chk("mv_one_cycle", msg_valid, 0);
    chk("write_busy", busy, 1);
    drive(4'b0000, 1'b1);
    chk("hold_busy", busy, 0);
    chk("hold_lcd_on", lcd_on, 1);

    // Same-code request dropped, then abierto waits for hold expiry
    step();
    drive(4'b0010, 1'b0);
    chk("same_flag_set", pending, 4'b0010);
    step();
    chk("same_flag_clr", pending, 4'b0000);
    chk("same_no_mv", msg_valid, 0);
    step(); step();
    first = 0;
    req_abierto = 1'b1;
    for (int k = 1; k <= 30 && first == 0; k++) begin
      step();
      req_abierto = 1'b0;
      if (msg_valid) first = k;
    end
    chk("abierto_latency", first, 16);
    chk("abierto_mns", mns, 2);

    // Intruso preempts hold at count 3
    drive(4'b0000, 1'b1);
    step(); step(); step();
    drive(4'b1000, 1'b0);
    chk("intr_flag", pending, 4'b1000);
    chk("intr_no_mv_yet", msg_valid, 0);
    step();
    chk("intr_mv", msg_valid, 1);
    chk("intr_mns", mns, 3);
    drive(4'b0000, 1'b1);
    off_cnt = 0;
    for (int k = 1; k <= 70; k++) begin
      lcd_done = (k == 10);
      step();
      if (!lcd_on) off_cnt++;
    end
    lcd_done = 1'b0;
    chk("intr_no_timeout", off_cnt, 0);
    chk("intr_busy", busy, 0);

    // Simultaneous usuario + abierto after expiry
    drive(4'b0101, 1'b0);
    chk("dual_flags", pending, 4'b0101);
    step();
    chk("dual_mv", msg_valid, 1);
    chk("dual_mns", mns, 2);
    chk("dual_left", pending, 4'b0001);
    drive(4'b0000, 1'b1);
    first = 0;
    for (int k = 1; k <= 40 && first == 0; k++) begin
      step();
      if (msg_valid) first = k;
    end
    chk("usuario_latency", first, HT + 1);
    chk("usuario_mns", mns, 0);

    // Idle power-down then presence wake
    drive(4'b0000, 1'b1);
    first = 0;
    for (int k = 1; k <= 70 && first == 0; k++) begin
      step();
      if (!lcd_on) first = k;
    end
    chk("idle_off_step", first, IT + 1);
    presence = 1'b1;
    step();
    chk("pres_wake_on", lcd_on, 1);
    chk("pres_wake_no_mv", msg_valid, 0);
    step();
    chk("pres_mv", msg_valid, 1);
    chk("pres_mns", mns, 0);
    presence = 1'b0;

    // Reset mid-write with lcd_done in flight
    drive(4'b0000, 1'b1);
    drive(4'b1000, 1'b0);
    step();
    chk("pre_rst_mns", mns, 3);
    reset = 1'b0;
    drive(4'b0000, 1'b1);
    chk("mid_rst_lcd_on", lcd_on, 0);
    chk("mid_rst_mns", mns, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mv", msg_valid, 0);
    chk("mid_rst_pending", pending, 4'b0000);
    reset = 1'b1;
    step(); step();
    chk("after_rst_off", lcd_on, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
